// File: rtl/flash_pkg.sv
// Shared definitions for the flash write path: pacer state encoding and
// SPI flash command timing constants.
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        WAIT = 2'b10
    } state_t;

    // 2 ms at 50 MHz; covers WREN + page-program framing plus tPP(max).
    localparam int DEF_GAP_CNT     = 100000;
    localparam int BYTE_SLOT_CLKS  = 32;
    localparam int SLOTS_PER_WRITE = 11;
    localparam int WRITE_SEQ_CLKS  = BYTE_SLOT_CLKS * SLOTS_PER_WRITE;

endpackage

// File: rtl/flash_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; read data is the word at the
// read pointer, consumed on the edge where rd_en is high.
module flash_byte_fifo
    import flash_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   cnt,
    output logic              full,
    output logic              empty
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH == 2**ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (ADDR_W+1)'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/flash_wr_byte_pacer.sv
// Buffers UART bytes and releases them one at a time to the SPI flash writer,
// spacing releases by GAP_CNT+1 clocks so each page program can complete.
module flash_wr_byte_pacer
    import flash_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int GAP_CNT = DEF_GAP_CNT,
    parameter int GAP_W   = 17
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              rx_flag,
    input  logic [7:0]        rx_data,
    input  logic              ovf_clr,
    output logic              pi_flag,
    output logic [7:0]        pi_data,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy
);

    state_t             state;
    state_t             state_nxt;
    logic               pop;
    logic               fifo_wr;
    logic               drop;
    logic               fifo_empty;
    logic [7:0]         fifo_dout;
    logic [GAP_W-1:0]   gap;
    logic               gap_done;

    // A full FIFO still accepts a byte when the same edge pops one.
    assign fifo_wr  = rx_flag && (!fifo_full || pop);
    assign drop     = rx_flag && fifo_full && !pop;
    assign gap_done = (gap == GAP_W'(GAP_CNT - 1));
    assign busy     = (state != IDLE) || (fifo_cnt != '0);

    flash_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .wr_en (fifo_wr),
        .rd_en (pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = WAIT;
            WAIT:    if (gap_done)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop = (state == IDLE) && !fifo_empty;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pi_flag <= 1'b0;
            pi_data <= '0;
            gap     <= '0;
        end else begin
            pi_flag <= pop;
            if (pop) begin
                pi_data <= fifo_dout;
                gap     <= '0;
            end else if (state == WAIT) begin
                gap     <= gap + 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flash_wr_byte_pacer.sv
// Scoreboard bench for flash_wr_byte_pacer with GAP_CNT shortened to 20 clocks.
module tb_flash_wr_byte_pacer;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int GAP_CNT = 20;
    localparam int GAP_W   = 5;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              rx_flag   = 1'b0;
    logic [7:0]        rx_data   = 8'h00;
    logic              ovf_clr   = 1'b0;
    logic              pi_flag;
    logic [7:0]        pi_data;
    logic [ADDR_W:0]   fifo_cnt;
    logic              fifo_full;
    logic              overflow;
    logic              busy;

    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          rise_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          peak  = 0;
    logic [7:0]  last_data = 8'h00;
    logic        prev_flag = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    flash_wr_byte_pacer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .GAP_CNT (GAP_CNT),
        .GAP_W   (GAP_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_flag   (rx_flag),
        .rx_data   (rx_data),
        .ovf_clr   (ovf_clr),
        .pi_flag   (pi_flag),
        .pi_data   (pi_data),
        .fifo_cnt  (fifo_cnt),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (int'(fifo_cnt) > peak) peak = int'(fifo_cnt);
    endtask

    task automatic send(input logic [7:0] b, input bit expect_out);
        rx_flag = 1'b1;
        rx_data = b;
        if (expect_out) exp_q.push_back(b);
        tick();
        rx_flag = 1'b0;
    endtask

    task automatic wait_flag(input int limit, output int rc);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!pi_flag && n < limit);
        if (!pi_flag) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_flag: no pi_flag within %0d cycles", limit);
        end
        rc = cyc;
    endtask

    task automatic wait_idle(input int limit, output int rc);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles", limit);
        end
        rc = cyc;
    endtask

    // Pops one expected byte per release and checks pulse width / data hold.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                last_data = pi_data;
                prev_flag = 1'b0;
            end else begin
                if (pi_flag) begin
                    rise_q.push_back(cyc);
                    n_vec++;
                    if (prev_flag) begin
                        n_err++;
                        $display("FAIL pi_flag_width: high in consecutive cycles at %0d", cyc);
                    end
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL release: got byte %02h, expected no release", pi_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (pi_data !== e) begin
                            n_err++;
                            $display("FAIL release_data: got %02h, expected %02h", pi_data, e);
                        end
                    end
                    last_data = pi_data;
                end else if (pi_data !== last_data) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL pi_data_hold: got %02h, expected %02h", pi_data, last_data);
                    last_data = pi_data;
                end
                prev_flag = pi_flag;
            end
        end
    endtask

    task automatic run_stim();
        int c0;
        int r;
        int ci;
        // Reset state
        repeat (3) tick();
        chk("rst_pi_flag",  int'(pi_flag),  0);
        chk("rst_pi_data",  int'(pi_data),  0);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_full",     int'(fifo_full), 0);
        sys_rst_n = 1'b1;
        repeat (5) tick();

        // Single byte: latency 2, busy clears 20 cycles after release
        rise_q.delete();
        c0 = cyc;
        send(8'hA5, 1'b1);
        wait_idle(100, ci);
        chk("single_pulses",  rise_q.size(), 1);
        chk("single_latency", rise_q[0] - c0, 2);
        chk("single_busy_gap", ci - rise_q[0], 20);
        repeat (30) tick();
        chk("single_hold", int'(pi_data), 8'hA5);

        // Burst of three
        rise_q.delete();
        peak = 0;
        c0 = cyc;
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        wait_idle(200, ci);
        chk("burst_peak",    peak, 2);
        chk("burst_pulses",  rise_q.size(), 3);
        chk("burst_latency", rise_q[0] - c0, 2);
        chk("burst_space1",  rise_q[1] - rise_q[0], GAP_CNT + 1);
        chk("burst_space2",  rise_q[2] - rise_q[1], GAP_CNT + 1);
        chk("burst_cnt_end", int'(fifo_cnt), 0);

        // Overflow while in WAIT, then full write alongside a pop
        send(8'h3C, 1'b1);
        wait_flag(10, r);
        for (int i = 0; i < 17; i++) begin
            send(8'(8'h40 + i), i < 16);
            if (i == 15) begin
                chk("ovf_full16",   int'(fifo_full), 1);
                chk("ovf_cnt16",    int'(fifo_cnt), 16);
                chk("ovf_not_yet",  int'(overflow), 0);
            end
            if (i == 16) begin
                chk("ovf_set",      int'(overflow), 1);
                chk("ovf_cnt17",    int'(fifo_cnt), 16);
            end
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        while (cyc < r + GAP_CNT) tick();
        send(8'hEE, 1'b1);
        chk("fullpop_flag", int'(pi_flag), 1);
        chk("fullpop_cnt",  int'(fifo_cnt), 16);
        chk("fullpop_ovf",  int'(overflow), 0);
        wait_idle(600, ci);
        chk("fullpop_drained", exp_q.size(), 0);

        // Wrap-around stream
        peak = 0;
        for (int i = 0; i < 40; i++) begin
            send(8'(i), 1'b1);
            repeat (14) tick();
        end
        wait_idle(1000, ci);
        chk("wrap_never_full", int'(peak < DEPTH), 1);
        chk("wrap_drained",    exp_q.size(), 0);
        chk("wrap_ovf",        int'(overflow), 0);

        // Reset in the middle of WAIT
        rise_q.delete();
        for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 1'b1);
        chk("rstw_cnt4", int'(fifo_cnt), 4);
        sys_rst_n = 1'b0;
        #1;
        chk("rstw_flag", int'(pi_flag),  0);
        chk("rstw_data", int'(pi_data),  0);
        chk("rstw_cnt",  int'(fifo_cnt), 0);
        chk("rstw_busy", int'(busy),     0);
        exp_q.delete();
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (40) tick();
        chk("rstw_no_release", rise_q.size(), 1);
        c0 = cyc;
        send(8'h77, 1'b1);
        wait_idle(100, ci);
        chk("rstw_new_pulses",  rise_q.size(), 2);
        chk("rstw_new_latency", rise_q[1] - c0, 2);
        chk("rstw_new_data",    int'(pi_data), 8'h77);
        repeat (3) tick();
    endtask

    initial begin
        fork
            begin
                run_stim();
            end
            begin
                monitor();
            end
            begin
                #100000;
                n_vec++;
                n_err++;
                $display("FAIL watchdog: stimulus did not complete in time");
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
